// File: rtl/mem_3port_pkg.sv
// ---------------------------------------------------------------------------
// mem_3port_pkg
// Shared definitions for the three-port data memory: bus command and access
// size encodings, memory geometry, and small helpers that turn an access size
// into byte/bit masks and an aligned line offset.
// ---------------------------------------------------------------------------
package mem_3port_pkg;

    localparam int XLEN            = 32;
    localparam int MEM_64BIT_LINES = 8192;
    localparam int LINE_IDX_W      = $clog2(MEM_64BIT_LINES);
    localparam int NUM_PORTS       = 3;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_command_e;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_e;

    // One bit per byte covered by an access of the given size, at offset 0.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        case (size)
            BYTE:    return 8'h01;
            HALF:    return 8'h03;
            WORD:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Clears the offset bits below the access size, so a misaligned address
    // behaves as the naturally aligned one containing it.
    function automatic logic [2:0] align_offset(input logic [2:0] offset,
                                                input logic [1:0] size);
        case (size)
            BYTE:    return offset;
            HALF:    return {offset[2:1], 1'b0};
            WORD:    return {offset[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    // Widens a per-byte mask into a per-bit mask.
    function automatic logic [63:0] expand_byte_mask(input logic [7:0] mask);
        logic [63:0] bits;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/mem_3port_if.sv
// ---------------------------------------------------------------------------
// mem_3port_if
// One processor-to-memory port. The processor side (master) drives command,
// byte address, LSB-justified store data and access size; the memory side
// (slave) returns a combinational accept response plus registered load data
// and a registered data-valid tag.
// ---------------------------------------------------------------------------
interface mem_3port_if
    import mem_3port_pkg::*;
();

    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [1:0]      proc2mem_size;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    modport master (
        output proc2mem_command,
        output proc2mem_addr,
        output proc2mem_data,
        output proc2mem_size,
        input  mem2proc_response,
        input  mem2proc_data,
        input  mem2proc_tag
    );

    modport slave (
        input  proc2mem_command,
        input  proc2mem_addr,
        input  proc2mem_data,
        input  proc2mem_size,
        output mem2proc_response,
        output mem2proc_data,
        output mem2proc_tag
    );

endinterface

// File: rtl/mem_3port_align.sv
// ---------------------------------------------------------------------------
// mem_port_align
// Purely combinational per-port datapath.
//   addr, size   : byte address and access size of the request
//   store_data   : LSB-justified store data
//   line_rdata   : current contents of the addressed 64-bit line
//   line_idx     : line index (address bits above the byte offset, wrapped)
//   byte_en      : bytes of the line touched by this access
//   line_wdata   : store data shifted into its byte lanes within the line
//   load_data    : addressed bytes shifted down to bit 0, zero-extended
// ---------------------------------------------------------------------------
module mem_port_align
    import mem_3port_pkg::*;
(
    input  logic [XLEN-1:0]       addr,
    input  logic [1:0]            size,
    input  logic [63:0]           store_data,
    input  logic [63:0]           line_rdata,
    output logic [LINE_IDX_W-1:0] line_idx,
    output logic [7:0]            byte_en,
    output logic [63:0]           line_wdata,
    output logic [63:0]           load_data
);

    logic [2:0]  offset;
    logic [5:0]  bit_shift;
    logic [63:0] size_mask;

    // Address bits above the line index are ignored so the memory wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[XLEN-1:3+LINE_IDX_W];

    assign line_idx = addr[3 +: LINE_IDX_W];

    always_comb begin
        offset     = align_offset(addr[2:0], size);
        bit_shift  = {offset, 3'b000};
        size_mask  = expand_byte_mask(size_byte_mask(size));
        byte_en    = size_byte_mask(size) << offset;
        line_wdata = (store_data & size_mask) << bit_shift;
        load_data  = (line_rdata >> bit_shift) & size_mask;
    end

endmodule

// File: rtl/mem_3port.sv
// ---------------------------------------------------------------------------
// mem_3port
// Three-port unified data memory of 64-bit lines, one load/store port per
// pipeline way.
//   clk      : rising-edge clock for all state
//   reset_n  : asynchronous active-low reset (clears load outputs only)
//   port0..2 : slave side of mem_3port_if, one per way
// Stores commit on the rising edge with per-byte priority port2 > port1 >
// port0. Loads read the pre-edge line and present zero-extended data with
// tag 1 during the following cycle. Every non-NONE command is accepted.
// ---------------------------------------------------------------------------
module mem_3port
    import mem_3port_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mem_3port_if.slave    port0,
    mem_3port_if.slave    port1,
    mem_3port_if.slave    port2
);

    logic [63:0] unified_memory [MEM_64BIT_LINES];

    logic [1:0]            cmd        [NUM_PORTS];
    logic [XLEN-1:0]       addr       [NUM_PORTS];
    logic [63:0]           store_data [NUM_PORTS];
    logic [1:0]            size       [NUM_PORTS];
    logic [LINE_IDX_W-1:0] line_idx   [NUM_PORTS];
    logic [7:0]            byte_en    [NUM_PORTS];
    logic [63:0]           line_wdata [NUM_PORTS];
    logic [63:0]           line_rdata [NUM_PORTS];
    logic [63:0]           load_data  [NUM_PORTS];
    logic                  is_load    [NUM_PORTS];
    logic                  is_store   [NUM_PORTS];
    logic [63:0]           rdata_q    [NUM_PORTS];
    logic [3:0]            tag_q      [NUM_PORTS];

    assign cmd[0]        = port0.proc2mem_command;
    assign cmd[1]        = port1.proc2mem_command;
    assign cmd[2]        = port2.proc2mem_command;
    assign addr[0]       = port0.proc2mem_addr;
    assign addr[1]       = port1.proc2mem_addr;
    assign addr[2]       = port2.proc2mem_addr;
    assign store_data[0] = port0.proc2mem_data;
    assign store_data[1] = port1.proc2mem_data;
    assign store_data[2] = port2.proc2mem_data;
    assign size[0]       = port0.proc2mem_size;
    assign size[1]       = port1.proc2mem_size;
    assign size[2]       = port2.proc2mem_size;

    // The illegal encoding 2'b11 matches neither and so acts as BUS_NONE.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            is_load[p]  = (cmd[p] == BUS_LOAD);
            is_store[p] = (cmd[p] == BUS_STORE);
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_port
        assign line_rdata[g] = unified_memory[line_idx[g]];

        mem_port_align u_align (
            .addr       (addr[g]),
            .size       (size[g]),
            .store_data (store_data[g]),
            .line_rdata (line_rdata[g]),
            .line_idx   (line_idx[g]),
            .byte_en    (byte_en[g]),
            .line_wdata (line_wdata[g]),
            .load_data  (load_data[g])
        );
    end

    // Storage is never cleared; reset only blocks writes while asserted.
    // Ports are visited in ascending order so, for any byte written by more
    // than one port on the same edge, the last (highest-index) write wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < 8; b++) begin
                    if (is_store[p] && byte_en[p][b]) begin
                        unified_memory[line_idx[p]][8*b +: 8] <= line_wdata[p][8*b +: 8];
                    end
                end
            end
        end
    end

    // Load results: sampled from the pre-edge line, zero outside load cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata_q[p] <= '0;
                tag_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata_q[p] <= is_load[p] ? load_data[p] : 64'd0;
                tag_q[p]   <= is_load[p] ? 4'd1 : 4'd0;
            end
        end
    end

    assign port0.mem2proc_response = (is_load[0] || is_store[0]) ? 4'd1 : 4'd0;
    assign port1.mem2proc_response = (is_load[1] || is_store[1]) ? 4'd1 : 4'd0;
    assign port2.mem2proc_response = (is_load[2] || is_store[2]) ? 4'd1 : 4'd0;

    assign port0.mem2proc_data = rdata_q[0];
    assign port1.mem2proc_data = rdata_q[1];
    assign port2.mem2proc_data = rdata_q[2];
    assign port0.mem2proc_tag  = tag_q[0];
    assign port1.mem2proc_tag  = tag_q[1];
    assign port2.mem2proc_tag  = tag_q[2];

endmodule

// File: tb/tb_mem_3port.sv
// ---------------------------------------------------------------------------
// tb_mem_3port
// Directed self-checking bench for mem_3port. Inputs change 1 ns after a
// rising edge; registered outputs are sampled at that same point, and the
// combinational response a further 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_3port;
    import mem_3port_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   passes;

    mem_3port_if p0 ();
    mem_3port_if p1 ();
    mem_3port_if p2 ();

    mem_3port dut (
        .clk     (clk),
        .reset_n (reset_n),
        .port0   (p0),
        .port1   (p1),
        .port2   (p2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one port's request fields.
    task automatic applyStimulus(input int port, input logic [1:0] cmd,
                                 input logic [31:0] addr, input logic [63:0] data,
                                 input logic [1:0] size);
        case (port)
            0: begin
                p0.proc2mem_command = cmd; p0.proc2mem_addr = addr;
                p0.proc2mem_data = data;   p0.proc2mem_size = size;
            end
            1: begin
                p1.proc2mem_command = cmd; p1.proc2mem_addr = addr;
                p1.proc2mem_data = data;   p1.proc2mem_size = size;
            end
            default: begin
                p2.proc2mem_command = cmd; p2.proc2mem_addr = addr;
                p2.proc2mem_data = data;   p2.proc2mem_size = size;
            end
        endcase
    endtask

    task automatic idleAll();
        for (int p = 0; p < 3; p++) applyStimulus(p, BUS_NONE, 32'd0, 64'd0, BYTE);
    endtask

    // Advances to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        reset_n = 1'b0;
        idleAll();

        // ---------------- reset state ----------------
        #12;
        checkOutput("reset_tag0",  {60'd0, p0.mem2proc_tag}, 64'd0);
        checkOutput("reset_tag1",  {60'd0, p1.mem2proc_tag}, 64'd0);
        checkOutput("reset_tag2",  {60'd0, p2.mem2proc_tag}, 64'd0);
        checkOutput("reset_data0", p0.mem2proc_data, 64'd0);
        checkOutput("reset_data1", p1.mem2proc_data, 64'd0);
        checkOutput("reset_data2", p2.mem2proc_data, 64'd0);
        checkOutput("idle_resp0",  {60'd0, p0.mem2proc_response}, 64'd0);
        reset_n = 1'b1;
        tick();

        // ---------------- WORD basic ----------------
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, BUS_STORE, 32'd0, 64'(k),     WORD);
            applyStimulus(1, BUS_STORE, 32'd4, 64'(k + 1), WORD);
            applyStimulus(2, BUS_STORE, 32'd8, 64'(k + 2), WORD);
            if (k == 0) begin
                #1;
                checkOutput("store_resp0", {60'd0, p0.mem2proc_response}, 64'd1);
                checkOutput("store_resp1", {60'd0, p1.mem2proc_response}, 64'd1);
                checkOutput("store_resp2", {60'd0, p2.mem2proc_response}, 64'd1);
            end
            tick();
            if (k == 0) checkOutput("store_cycle_tag0", {60'd0, p0.mem2proc_tag}, 64'd0);
            applyStimulus(0, BUS_LOAD, 32'd0, 64'd0, WORD);
            applyStimulus(1, BUS_LOAD, 32'd4, 64'd0, WORD);
            applyStimulus(2, BUS_LOAD, 32'd8, 64'd0, WORD);
            tick();
            checkOutput("word_load0", p0.mem2proc_data, 64'(k));
            checkOutput("word_load1", p1.mem2proc_data, 64'(k + 1));
            checkOutput("word_load2", p2.mem2proc_data, 64'(k + 2));
            checkOutput("word_tag2",  {60'd0, p2.mem2proc_tag}, 64'd1);
        end
        idleAll();
        tick();
        checkOutput("idle_tag0",  {60'd0, p0.mem2proc_tag}, 64'd0);
        checkOutput("idle_data0", p0.mem2proc_data, 64'd0);

        // ---------------- same-address conflicts (k = 5) ----------------
        applyStimulus(0, BUS_STORE, 32'd12, 64'd5, WORD);
        applyStimulus(1, BUS_STORE, 32'd12, 64'd6, WORD);
        applyStimulus(2, BUS_STORE, 32'd12, 64'd7, WORD);
        tick();
        applyStimulus(0, BUS_STORE, 32'd16, 64'd5, WORD);
        applyStimulus(1, BUS_STORE, 32'd16, 64'd6, WORD);
        applyStimulus(2, BUS_NONE,  32'd0,  64'd0, WORD);
        tick();
        applyStimulus(0, BUS_NONE,  32'd0,  64'd0, WORD);
        applyStimulus(1, BUS_STORE, 32'd28, 64'd6, WORD);
        applyStimulus(2, BUS_STORE, 32'd28, 64'd7, WORD);
        tick();
        applyStimulus(0, BUS_STORE, 32'd32, 64'd5, WORD);
        applyStimulus(1, BUS_STORE, 32'd36, 64'd6, WORD);
        applyStimulus(2, BUS_STORE, 32'd32, 64'd7, WORD);
        tick();
        applyStimulus(0, BUS_LOAD, 32'd12, 64'd0, WORD);
        applyStimulus(1, BUS_LOAD, 32'd16, 64'd0, WORD);
        applyStimulus(2, BUS_LOAD, 32'd28, 64'd0, WORD);
        tick();
        checkOutput("conflict_012_at12", p0.mem2proc_data, 64'd7);
        checkOutput("conflict_01_at16",  p1.mem2proc_data, 64'd6);
        checkOutput("conflict_12_at28",  p2.mem2proc_data, 64'd7);
        applyStimulus(0, BUS_LOAD, 32'd32, 64'd0, WORD);
        applyStimulus(1, BUS_LOAD, 32'd36, 64'd0, WORD);
        applyStimulus(2, BUS_NONE, 32'd0,  64'd0, WORD);
        tick();
        checkOutput("conflict_02_at32", p0.mem2proc_data, 64'd7);
        checkOutput("port1_at36",       p1.mem2proc_data, 64'd6);

        // Read-before-write on the same bytes.
        applyStimulus(0, BUS_LOAD,  32'd12, 64'd0,  WORD);
        applyStimulus(1, BUS_NONE,  32'd0,  64'd0,  WORD);
        applyStimulus(2, BUS_STORE, 32'd12, 64'h63, WORD);
        tick();
        checkOutput("rbw_old_value", p0.mem2proc_data, 64'd7);
        idleAll();
        applyStimulus(1, BUS_LOAD, 32'd12, 64'd0, WORD);
        tick();
        checkOutput("rbw_new_value", p1.mem2proc_data, 64'h63);

        // ---------------- BYTE merge (k = 9) ----------------
        idleAll();
        applyStimulus(0, BUS_STORE, 32'd40, 64'hDEAD_BEEF, WORD);
        tick();
        applyStimulus(0, BUS_STORE, 32'd40, 64'hFFFF_FFFF_FFFF_FF09, BYTE);
        applyStimulus(1, BUS_STORE, 32'd41, 64'h06, BYTE);
        applyStimulus(2, BUS_STORE, 32'd42, 64'h0E, BYTE);
        tick();
        applyStimulus(0, BUS_LOAD, 32'd40, 64'd0, BYTE);
        applyStimulus(1, BUS_LOAD, 32'd41, 64'd0, BYTE);
        applyStimulus(2, BUS_LOAD, 32'd42, 64'd0, BYTE);
        tick();
        checkOutput("byte_load40", p0.mem2proc_data, 64'h09);
        checkOutput("byte_load41", p1.mem2proc_data, 64'h06);
        checkOutput("byte_load42", p2.mem2proc_data, 64'h0E);

        // ---------------- HALF / DOUBLE ----------------
        applyStimulus(0, BUS_STORE, 32'd44, 64'hAAAA_AAAA_AAAA_0009, HALF);
        applyStimulus(1, BUS_STORE, 32'd46, 64'h0006, HALF);
        applyStimulus(2, BUS_STORE, 32'd48, 64'h000E, HALF);
        tick();
        applyStimulus(0, BUS_STORE, 32'd56, 64'h0123_4567_89AB_CDEF, DOUBLE);
        applyStimulus(1, BUS_STORE, 32'd64, 64'hFEDC_BA98_7654_3210, DOUBLE);
        applyStimulus(2, BUS_STORE, 32'd72, 64'h8000_0000_0000_0001, DOUBLE);
        tick();
        applyStimulus(0, BUS_LOAD, 32'd44, 64'd0, HALF);
        applyStimulus(1, BUS_LOAD, 32'd46, 64'd0, HALF);
        applyStimulus(2, BUS_LOAD, 32'd48, 64'd0, HALF);
        tick();
        checkOutput("half_load44", p0.mem2proc_data, 64'h0009);
        checkOutput("half_load46", p1.mem2proc_data, 64'h0006);
        checkOutput("half_load48", p2.mem2proc_data, 64'h000E);
        applyStimulus(0, BUS_LOAD, 32'd56, 64'd0, DOUBLE);
        applyStimulus(1, BUS_LOAD, 32'd64, 64'd0, DOUBLE);
        applyStimulus(2, BUS_LOAD, 32'd72, 64'd0, DOUBLE);
        tick();
        checkOutput("double_load56", p0.mem2proc_data, 64'h0123_4567_89AB_CDEF);
        checkOutput("double_load64", p1.mem2proc_data, 64'hFEDC_BA98_7654_3210);
        checkOutput("double_load72", p2.mem2proc_data, 64'h8000_0000_0000_0001);
        applyStimulus(0, BUS_LOAD, 32'd40, 64'd0, WORD);
        applyStimulus(1, BUS_LOAD, 32'd45, 64'd0, HALF);
        applyStimulus(2, BUS_LOAD, 32'd58, 64'd0, WORD);
        tick();
        checkOutput("word40_intact",   p0.mem2proc_data, 64'hDE0E_0609);
        checkOutput("half45_aligned",  p1.mem2proc_data, 64'h0009);
        checkOutput("word58_aligned",  p2.mem2proc_data, 64'h89AB_CDEF);
        applyStimulus(0, BUS_LOAD, 32'd61,    64'd0, DOUBLE);
        applyStimulus(1, BUS_LOAD, 32'd65600, 64'd0, DOUBLE);
        applyStimulus(2, BUS_LOAD, 32'd44,    64'd0, WORD);
        tick();
        checkOutput("double61_aligned", p0.mem2proc_data, 64'h0123_4567_89AB_CDEF);
        checkOutput("double_wrap64",    p1.mem2proc_data, 64'hFEDC_BA98_7654_3210);
        checkOutput("word44_halves",    p2.mem2proc_data, 64'h0006_0009);
        applyStimulus(0, BUS_LOAD, 32'd57, 64'd0, BYTE);
        applyStimulus(1, BUS_NONE, 32'd0,  64'd0, BYTE);
        applyStimulus(2, BUS_NONE, 32'd0,  64'd0, BYTE);
        tick();
        checkOutput("byte57", p0.mem2proc_data, 64'hCD);
        checkOutput("idle_after_load_tag1", {60'd0, p1.mem2proc_tag}, 64'd0);

        // ---------------- illegal command ----------------
        applyStimulus(0, 2'b11, 32'd56, 64'd0, DOUBLE);
        #1;
        checkOutput("illegal_resp", {60'd0, p0.mem2proc_response}, 64'd0);
        tick();
        checkOutput("illegal_tag",  {60'd0, p0.mem2proc_tag}, 64'd0);
        checkOutput("illegal_data", p0.mem2proc_data, 64'd0);

        // ---------------- latency and reset mid-load ----------------
        applyStimulus(0, BUS_LOAD, 32'd56, 64'd0, DOUBLE);
        tick();
        checkOutput("latency_tag0", {60'd0, p0.mem2proc_tag}, 64'd1);
        applyStimulus(1, BUS_STORE, 32'd56, 64'hFFFF_FFFF_FFFF_FFFF, DOUBLE);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_tag0",  {60'd0, p0.mem2proc_tag}, 64'd0);
        checkOutput("async_reset_data0", p0.mem2proc_data, 64'd0);
        tick();
        checkOutput("in_reset_tag0", {60'd0, p0.mem2proc_tag}, 64'd0);
        idleAll();
        reset_n = 1'b1;
        applyStimulus(0, BUS_LOAD, 32'd56, 64'd0, DOUBLE);
        applyStimulus(1, BUS_LOAD, 32'd12, 64'd0, WORD);
        tick();
        checkOutput("retained56", p0.mem2proc_data, 64'h0123_4567_89AB_CDEF);
        checkOutput("retained12", p1.mem2proc_data, 64'h63);
        idleAll();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
